pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage core. It produces the `stall[5:0]` vector and the IF/ID and ID/EX flush strobes consumed by the pipeline registers, and resolves taken branches from EX into a PC redirect. It holds that redirect across an in-flight instruction fetch. It also keeps saturating stall and flush performance counters. It sits beside the pipeline and drives every stage register and the PC unit.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk` input 1: core clock; the only clock.
- `rst` input 1: synchronous, active-high reset (`RstEnable`).
- `stallreq_if` input 1: fetch in progress, instruction not yet returned.
- `stallreq_id` input 1: load-use hazard detected in ID.
- `stallreq_mem` input 1: data memory access not complete.
- `ex_branch_taken` input 1: the instruction in EX is a taken branch or jump.
- `ex_branch_target` input 32: redirect PC, valid with `ex_branch_taken`.
- `stall` output 6: bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; `Stop`=1.
- `if_idflush_o` output 1: squash the IF/ID register this edge.
- `id_exflush_o` output 1: squash the ID/EX register this edge.
- `redirect_valid_o` output 1: the PC unit loads `redirect_pc_o` at this edge.
- `redirect_pc_o` output 32: redirect target.
- `stall_cycles_o` output CNT_W: count of cycles with `stall[0]`=Stop.
- `flush_count_o` output CNT_W: count of accepted branches.

## Operation
- Stall priority is fixed: mem > id > if.
  - `stallreq_mem` gives `stall`=6'b011111.
  - Otherwise `stallreq_id` gives 6'b000111.
  - Otherwise `stallreq_if` gives 6'b000011.
  - Otherwise `stall`=6'b000000.
- The stage where the stop ends receives a bubble. The downstream register implements this (stall[n]=Stop, stall[n+1]=NoStop).
- A branch is accepted only when `ex_branch_taken`=1 and `stall[3]`=NoStop. While EX is frozen, the branch is held off; it is not lost.
- The FSM has two states, IDLE and WAIT.
- IDLE, branch accepted, `stallreq_if`=0:
  - assert `id_exflush_o`, `if_idflush_o` and `redirect_valid_o`, with `redirect_pc_o`=`ex_branch_target`;
  - stay in IDLE;
  - increment `flush_count_o`.
- IDLE, branch accepted, `stallreq_if`=1:
  - assert `id_exflush_o`;
  - latch the target into `pend_pc`;
  - go to WAIT;
  - increment `flush_count_o`.
- WAIT:
  - `redirect_valid_o`=0;
  - `redirect_pc_o`=`pend_pc`.
- WAIT, `stallreq_if` falls to 0 (the stale fetch returns):
  - assert `if_idflush_o` and `redirect_valid_o` with `pend_pc`;
  - return to IDLE.
- `ex_branch_taken` in WAIT is ignored. EX holds a bubble in this state, so a taken branch here is a protocol error; the bench asserts it never occurs.
- Flush overrides stall in every register.
- In IDLE with no accepted branch, `redirect_pc_o`=0.
- Counters saturate at all-ones and never wrap.
  - `stall_cycles_o` increments on every cycle with `stall[0]`=Stop, including the cycles spent in WAIT.

## Timing
- `stall`, both flush outputs, `redirect_valid_o` and `redirect_pc_o` are combinational from the inputs and the current state. They take effect at the next `clk` edge, with zero-cycle latency.
- FSM, `pend_pc` and both counters update on `posedge clk`.
- Reset is synchronous.
  - Effect on the next edge: state IDLE, `pend_pc`=0, both counters 0.
  - Outputs while `rst`=1: `stall`=0, flushes 0, `redirect_valid_o`=0, `redirect_pc_o`=0.
- Reset in WAIT abandons the pending redirect.
- A branch accepted in the same cycle as `stallreq_id`: the branch wins for flush. `stall`=6'b000111 still, and ID/EX receives the flush.
- A branch with `stallreq_mem` is not accepted; it is taken on the first cycle `stallreq_mem` drops.
- `stallreq_if` that stays high for N cycles keeps WAIT for N cycles. The redirect occurs on the first cycle it is low.

## Structure
- Add to `defines.v`:
  - `StallBus` (5:0);
  - the stall pattern constants `StallMem`, `StallId`, `StallIf`, `StallNone`;
  - FSM encodings `CtrlIdle`, `CtrlWait`.
- Reuse the existing `Stop`, `NoStop`, `RstEnable` and `ZeroWord`.
- Natural sub-module: `sat_counter`, parameterised by width with `inc` and `clr` inputs, instantiated twice.

## Test plan
- `stallreq_mem`=1 together with `stallreq_id`=1 -> `stall`=6'b011111 and no flush. Drop both -> `stall`=0 next cycle.
- Branch to 0x0000_1000 with no stall -> one cycle of both flushes and `redirect_valid_o`=1, `redirect_pc_o`=0x1000; `flush_count_o`=1.
- Branch to 0x2000 while `stallreq_if` stays high 3 cycles -> `id_exflush_o` only, then WAIT for 3 cycles with `redirect_valid_o`=0. On the 4th cycle, `if_idflush_o`=1 and redirect to 0x2000.
- Branch held with `stallreq_mem`=1 for 2 cycles -> no flush during those cycles. Flush and redirect occur on the cycle `stallreq_mem` drops.
- `rst` asserted in WAIT -> next cycle state IDLE, no redirect ever issued, counters 0.
- Force `stall_cycles_o` to 0xFFFF_FFFE via the testbench-only preload hook, then stall 3 cycles -> `stall_cycles_o` reaches 0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall bus patterns, stop levels and controller state encodings
package pipe_ctrl_pkg;
    typedef logic [5:0] stall_bus_t;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam logic RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam stall_bus_t StallMem = 6'b011111;
    localparam stall_bus_t StallId = 6'b000111;
    localparam stall_bus_t StallIf = 6'b000011;
    localparam stall_bus_t StallNone = 6'b000000;
    typedef enum logic {CtrlIdle = 1'b0, CtrlWait = 1'b1} ctrl_state_t;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: counter that clears on clr and sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk)
        r_cnt <= clr ? '0 : (inc && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush generation, branch redirect held across an in-flight fetch, perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_mem,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    output logic [5:0]       stall,
    output logic             if_idflush_o,
    output logic             id_exflush_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);
    ctrl_state_t r_state, w_next;
    logic [31:0] r_pend_pc;
    logic w_rst, w_wait, w_accept, w_fire;
    always_ff @(posedge clk) begin
        r_state <= w_next;
        r_pend_pc <= w_rst ? ZeroWord : (w_accept && stallreq_if) ? ex_branch_target : r_pend_pc;
    end
    always_comb begin
        w_rst = rst == RstEnable;
        w_wait = r_state == CtrlWait;
        stall = w_rst ? StallNone : stallreq_mem ? StallMem : stallreq_id ? StallId
              : stallreq_if ? StallIf : StallNone;
        w_accept = !w_rst && !w_wait && ex_branch_taken && stall[3] == NoStop;
        w_fire = w_wait ? !w_rst && !stallreq_if : w_accept && !stallreq_if;
        id_exflush_o = w_accept;
        if_idflush_o = w_fire;
        redirect_valid_o = w_fire;
        redirect_pc_o = w_rst ? ZeroWord : w_wait ? r_pend_pc : w_fire ? ex_branch_target : ZeroWord;
        w_next = w_rst ? CtrlIdle : w_wait ? (stallreq_if ? CtrlWait : CtrlIdle)
               : (w_accept && stallreq_if) ? CtrlWait : CtrlIdle;
    end
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk),
        .inc(stall[0] == Stop),
        .clr(w_rst),
        .cnt(stall_cycles_o)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk),
        .inc(w_accept),
        .clr(w_rst),
        .cnt(flush_count_o)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a behavioural pipeline-controller model
module tb_pipe_ctrl;
    localparam int CNT_W = 32;
    localparam longint CAP = (64'd1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst, stallreq_if, stallreq_id, stallreq_mem, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [5:0] stall;
    logic if_idflush_o, id_exflush_o, redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [CNT_W-1:0] stall_cycles_o, flush_count_o;
    int n_vec = 0;
    int n_err = 0;
    bit m_wait = 1'b0;
    logic [31:0] m_pc = '0;
    longint m_stall_cnt = 0;
    longint m_flush_cnt = 0;
    always #5 clk = ~clk;
    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_mem(stallreq_mem),
        .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .stall(stall),
        .if_idflush_o(if_idflush_o),
        .id_exflush_o(id_exflush_o),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o),
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o(flush_count_o)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic m, input logic d, input logic f,
                        input logic b, input logic [31:0] t);
        int n;
        logic [5:0] e_stall;
        logic acc, fire;
        logic [31:0] e_pc;
        rst = r;
        stallreq_mem = m;
        stallreq_id = d;
        stallreq_if = f;
        ex_branch_taken = b;
        ex_branch_target = t;
        assert (r || !(m_wait && b)) else $error("taken branch while redirect pending");
        n = r ? 0 : m ? 5 : d ? 3 : f ? 2 : 0;
        e_stall = 6'((1 << n) - 1);
        acc = !r && !m_wait && b && !m;
        fire = r ? 1'b0 : m_wait ? !f : acc && !f;
        e_pc = r ? 32'h0 : m_wait ? m_pc : fire ? t : 32'h0;
        #3;
        chk("stall", stall, e_stall);
        chk("id_exflush", id_exflush_o, acc);
        chk("if_idflush", if_idflush_o, fire);
        chk("redirect_valid", redirect_valid_o, fire);
        chk("redirect_pc", redirect_pc_o, e_pc);
        chk("stall_cycles", stall_cycles_o, m_stall_cnt);
        chk("flush_count", flush_count_o, m_flush_cnt);
        if (r) begin
            m_wait = 1'b0;
            m_pc = '0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (e_stall != 0 && m_stall_cnt < CAP) m_stall_cnt++;
            if (acc && m_flush_cnt < CAP) m_flush_cnt++;
            if (m_wait) m_wait = f;
            else if (acc && f) begin
                m_wait = 1'b1;
                m_pc = t;
            end
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        {stallreq_if, stallreq_id, stallreq_mem, ex_branch_taken} = '0;
        ex_branch_target = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 32'hDEAD_BEEF);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0000_1000);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h0000_2000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h0000_3000);
        step(0, 1, 0, 0, 1, 32'h0000_3000);
        step(0, 0, 0, 0, 1, 32'h0000_3000);
        step(0, 0, 1, 0, 1, 32'h0000_4000);
        step(0, 0, 0, 1, 1, 32'h0000_5000);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        force dut.u_stall_cnt.r_cnt = 32'hFFFF_FFFE;
        m_stall_cnt = 64'hFFFF_FFFE;
        step(0, 0, 0, 0, 0, 0);
        release dut.u_stall_cnt.r_cnt;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic b;
            b = !m_wait && ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, b, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
